zmod_adc_cal_decim: RTL
=======================

Name: zmod_adc_cal_decim

Overview:
Post-processing stage that consumes the two 14-bit two's-complement sample streams (channel A/B) produced by the ZMOD ADC driver.
- Per channel: applies gain/offset calibration with saturation, then boxcar-averages and decimates by 2^DECIM_LOG2.
- Outputs a full-rate calibrated stream and a decimated stream, each with a one-cycle valid strobe, for the capture/DMA logic downstream.
- Single clock domain. Input samples are already retimed into clk.

Parameters:
DECIM_LOG2, 3, log2 of the decimation/averaging ratio. Legal range 0..8; 0 means pass-through at full rate.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
i14_data_a  input  14  signed ADC sample, channel A, one per clk
i14_data_b  input  14  signed ADC sample, channel B, one per clk
i_adc_configured  input  1  high once the ADC driver has finished SPI configuration
i_enable  input  1  processing enable
i16_gain_a  input  16  signed gain, channel A, Q2.14 (16384 = 1.0)
i16_gain_b  input  16  signed gain, channel B, Q2.14
i14_offset_a  input  14  signed offset, channel A, in LSB
i14_offset_b  input  14  signed offset, channel B, in LSB
i_clear_flags  input  1  clears the sticky saturation flags
o14_cal_a  output  14  calibrated full-rate sample, channel A
o14_cal_b  output  14  calibrated full-rate sample, channel B
o_cal_valid  output  1  strobe, o14_cal_a/b valid
o14_avg_a  output  14  decimated average, channel A
o14_avg_b  output  14  decimated average, channel B
o_avg_valid  output  1  one-cycle strobe per decimated output
o_sat_a  output  1  sticky: channel A calibration saturated
o_sat_b  output  1  sticky: channel B calibration saturated

Behaviour:
- Reset values: every output is 0; the accumulators, the sample counter and the valid pipeline are cleared.
- Qualifier: q = i_enable & i_adc_configured, sampled together with the data each cycle.
- Stage 1 (cycle n+1):
  - Register p = x * gain, 30-bit signed, exact.
  - Register v1 = q.
- Stage 2 (cycle n+2):
  - s = (p >>> 14) + sign-extended offset, computed at ≥17 bits. The shift is arithmetic, so it truncates toward -inf.
  - Saturate s to [-8192, 8191] and register the result to o14_cal_x.
  - o_cal_valid = v1 registered.
- Calibration latency is 2 cycles from input to o14_cal_x/o_cal_valid.
- Sticky flags:
  - o_sat_x is set on any stage-2 cycle with v1 = 1 where saturation occurred.
  - i_clear_flags clears it.
  - If set and clear occur in the same cycle, set wins.
- Gain and offset are used combinationally at stages 1 and 2. Software changes them only while i_enable = 0; a mid-stream change takes effect on the next sample, with no glitch protection.
- Decimator: one accumulator per channel, (14+DECIM_LOG2) bits signed, plus a shared counter cnt of 0..2^DECIM_LOG2-1.
  - On each cycle with o_cal_valid = 1:
    - If cnt < 2^N-1: acc += cal, cnt++.
    - If cnt == 2^N-1: o14_avg_x <= (acc + cal) >>> N, taking the low 14 bits (in range by construction). Then o_avg_valid <= 1, acc <= 0, cnt <= 0.
  - o_avg_valid is 0 on every other cycle; o14_avg_x holds its last value.
  - Averaging truncates toward -inf. Accumulation cannot overflow.
- Latency: o_avg_valid rises 3 cycles after the last contributing raw sample is presented at the input.
- Output rate:
  - With q held high: exactly one o_avg_valid every 2^N cycles.
  - With N = 0: o_avg_valid = o_cal_valid delayed by 1 cycle, and o14_avg equals o14_cal delayed by 1 cycle.
- Disable: in any cycle where q = 0, v1, o_cal_valid, acc and cnt clear on the next edge. The partial frame is discarded and no o_avg_valid is produced for it. Samples already in stage 1 are dropped.
- Re-enable: the first frame starts with cnt = 0, so output is frame-aligned to the enable edge.
- Reset mid-frame: everything clears as on power-up, with no spurious o_avg_valid.
- Channels A and B share q, cnt and the valid strobes. They are always aligned.

Test Plan:
1. gain=16384, offset=0, N=3, x_a=1000 constant, q=1 → o14_cal_a=1000 from cycle 2; o_avg_valid every 8 cycles with o14_avg_a=1000; o_sat_a=0.
2. gain_a=32767, x_a=5000 → (163835000>>>14)=9999, so o14_cal_a=8191 and o_sat_a=1. Assert i_clear_flags with x_a=0 → o_sat_a=0. Assert clear together with a saturating sample → o_sat_a stays 1.
3. gain=16384, offset_b=-100, x_b=-8192 → o14_cal_b=-8192, o_sat_b=1. Then x_b=0 → o14_cal_b=-100.
4. N=3, ramp x_a=0..7 → o14_avg_a=3. All x=-1 → -1. Alternating -1/0 → sum -4, so o14_avg_a=-1 (floor).
5. Drop i_enable after 5 samples of a frame, then re-raise → no o_avg_valid for the partial frame; the next o_avg_valid comes exactly 8 qualified samples plus 3 cycles after the re-enable.
6. i_adc_configured=0 with i_enable=1 → no valids. Assert rst mid-frame → all outputs 0, and the next frame is counted from 0. Repeat with N=0 → o_avg_valid on every cycle after a 3-cycle latency.

Source files
------------

// File: rtl/zmod_adc_cal_decim.sv
// zmod_adc_cal_decim: per-channel gain/offset calibration with saturation, then boxcar average + decimate by 2^DECIM_LOG2.
// Latency: 2 cycles input -> o14_cal_x/o_cal_valid; 3 cycles last contributing sample -> o_avg_valid.
// No backpressure: one sample per clk; dropping the qualifier flushes stage 1 and discards the partial frame.
module zmod_adc_cal_decim #(
  parameter int DECIM_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] i14_data_a,
  input  logic [13:0] i14_data_b,
  input  logic        i_adc_configured,
  input  logic        i_enable,
  input  logic [15:0] i16_gain_a,
  input  logic [15:0] i16_gain_b,
  input  logic [13:0] i14_offset_a,
  input  logic [13:0] i14_offset_b,
  input  logic        i_clear_flags,
  output logic [13:0] o14_cal_a,
  output logic [13:0] o14_cal_b,
  output logic        o_cal_valid,
  output logic [13:0] o14_avg_a,
  output logic [13:0] o14_avg_b,
  output logic        o_avg_valid,
  output logic        o_sat_a,
  output logic        o_sat_b
);

  // Accumulator holds up to 2^N full-scale 14-bit samples without overflow.
  localparam int AW = 14 + DECIM_LOG2;
  // Counter needs at least one bit even in pass-through mode.
  localparam int CW = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << DECIM_LOG2) - 1);

  // Returns {saturated, clamped 14-bit value}.
  function automatic logic [14:0] sat14(input logic signed [29:0] s);
    logic [14:0] r;
    if (s > 30'sd8191) begin
      r = {1'b1, 14'h1FFF};
    end else if (s < -30'sd8192) begin
      r = {1'b1, 14'h2000};
    end else begin
      r = {1'b0, s[13:0]};
    end
    return r;
  endfunction

  logic qual;
  assign qual = i_enable & i_adc_configured;

  // Stage 1: exact products and the qualifier that travels with them.
  logic signed [29:0] prod_a_d, prod_b_d, prod_a_q, prod_b_q;
  logic               v1_d, v1_q;

  assign prod_a_d = 30'($signed(i14_data_a)) * 30'($signed(i16_gain_a));
  assign prod_b_d = 30'($signed(i14_data_b)) * 30'($signed(i16_gain_b));
  assign v1_d     = qual;

  // Stage 1 register: products and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_a_q <= '0;
      prod_b_q <= '0;
      v1_q     <= 1'b0;
    end else begin
      prod_a_q <= prod_a_d;
      prod_b_q <= prod_b_d;
      v1_q     <= v1_d;
    end
  end

  // Stage 2: scale back from Q2.14 (floor), add offset, clamp to 14 bits.
  logic signed [29:0] sum_a, sum_b;
  logic [14:0]        satres_a, satres_b;
  logic signed [13:0] cal_a_d, cal_b_d, cal_a_q, cal_b_q;
  logic               cal_valid_d, cal_valid_q;
  logic               sat_a_d, sat_b_d, sat_a_q, sat_b_q;

  assign sum_a    = (prod_a_q >>> 14) + 30'($signed(i14_offset_a));
  assign sum_b    = (prod_b_q >>> 14) + 30'($signed(i14_offset_b));
  assign satres_a = sat14(sum_a);
  assign satres_b = sat14(sum_b);

  // Stage 2 next state; a qualifier drop also kills the sample sitting in stage 1.
  always_comb begin
    cal_a_d     = satres_a[13:0];
    cal_b_d     = satres_b[13:0];
    cal_valid_d = v1_q & qual;
    // Setting has priority over clearing so a saturation event is never lost.
    sat_a_d     = (v1_q & satres_a[14]) | (sat_a_q & ~i_clear_flags);
    sat_b_d     = (v1_q & satres_b[14]) | (sat_b_q & ~i_clear_flags);
  end

  // Stage 2 register: calibrated samples, valid and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cal_a_q     <= '0;
      cal_b_q     <= '0;
      cal_valid_q <= 1'b0;
      sat_a_q     <= 1'b0;
      sat_b_q     <= 1'b0;
    end else begin
      cal_a_q     <= cal_a_d;
      cal_b_q     <= cal_b_d;
      cal_valid_q <= cal_valid_d;
      sat_a_q     <= sat_a_d;
      sat_b_q     <= sat_b_d;
    end
  end

  // Decimator: shared frame counter, one accumulator per channel.
  logic signed [AW-1:0] acc_a_d, acc_b_d, acc_a_q, acc_b_q;
  logic signed [AW-1:0] dsum_a, dsum_b;
  logic [CW-1:0]        cnt_d, cnt_q;
  logic signed [13:0]   avg_a_d, avg_b_d, avg_a_q, avg_b_q;
  logic                 avg_valid_d, avg_valid_q;

  assign dsum_a = acc_a_q + AW'(cal_a_q);
  assign dsum_b = acc_b_q + AW'(cal_b_q);

  // Decimator next state: accumulate, emit floor-average on the last sample of a frame.
  always_comb begin
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    cnt_d       = cnt_q;
    avg_a_d     = avg_a_q;
    avg_b_d     = avg_b_q;
    avg_valid_d = 1'b0;
    if (!qual) begin
      // Partial frame discarded; next frame aligns to the enable edge.
      acc_a_d = '0;
      acc_b_d = '0;
      cnt_d   = '0;
    end else if (cal_valid_q) begin
      if (cnt_q == CNT_LAST) begin
        // Sum of 2^N in-range samples shifted by N is back in 14-bit range.
        avg_a_d     = dsum_a[AW-1:DECIM_LOG2];
        avg_b_d     = dsum_b[AW-1:DECIM_LOG2];
        avg_valid_d = 1'b1;
        acc_a_d     = '0;
        acc_b_d     = '0;
        cnt_d       = '0;
      end else begin
        acc_a_d = dsum_a;
        acc_b_d = dsum_b;
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  // Decimator state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      cnt_q       <= '0;
      avg_a_q     <= '0;
      avg_b_q     <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      cnt_q       <= cnt_d;
      avg_a_q     <= avg_a_d;
      avg_b_q     <= avg_b_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  assign o14_cal_a   = cal_a_q;
  assign o14_cal_b   = cal_b_q;
  assign o_cal_valid = cal_valid_q;
  assign o14_avg_a   = avg_a_q;
  assign o14_avg_b   = avg_b_q;
  assign o_avg_valid = avg_valid_q;
  assign o_sat_a     = sat_a_q;
  assign o_sat_b     = sat_b_q;

endmodule
